// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the bit-serial ALU scheduler.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ALU_CTRL_W = 2;
    localparam int NUM_REQ    = 2;

endpackage

// File: rtl/alu_seq_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves to the losing side on every grant.
module alu_seq_rr_arb
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    logic ptr_q;

    always_comb begin
        grant_idx = 1'b0;
        grant     = '0;
        if (enable) begin
            // Pointer only breaks ties; a lone requester always wins.
            if (valid[0] && valid[1]) grant_idx = ptr_q;
            else                      grant_idx = valid[1];
            grant = valid & (2'b01 << grant_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr_q <= 1'b0;
        else if (|grant) ptr_q <= ~grant_idx;
    end

endmodule

// File: rtl/alu_bitserial_sched.sv
// Shares one 1-bit ALU between two requesters, computing WIDTH-bit results LSB first.
// Optional res_zero output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_bitserial_sched
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*WIDTH-1:0]      req_b,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_op,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [WIDTH-1:0]              res_data,
    output logic                          res_id,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                          res_zero,
`endif
    output logic                          alu_a,
    output logic                          alu_b,
    output logic [ALU_CTRL_W-1:0]         alu_ctrl,
    input  logic                          alu_res
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_idx;
    logic                  accept;
    logic [WIDTH-1:0]      a_q, b_q, res_q;
    logic [ALU_CTRL_W-1:0] op_q;
    logic                  id_q;
    logic [CNT_W-1:0]      cnt_q;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // req_ready never depends on itself, and res_valid holds with stable data until taken.
    alu_seq_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .enable    ((state_q == IDLE) && rst_n),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign res_data  = res_q;
    assign res_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        res_valid = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_ctrl  = '0;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                alu_a    = a_q[0];
                alu_b    = b_q[0];
                alu_ctrl = op_q;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q   <= grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    b_q   <= grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    op_q  <= grant_idx ? req_op[3:2] : req_op[1:0];
                    id_q  <= grant_idx;
                    cnt_q <= '0;
                    res_q <= '0;
                end
                EXEC: begin
                    // Result fills from the top so bit 0 lands in place after WIDTH shifts.
                    res_q <= {alu_res, res_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic any_one_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           any_one_q <= 1'b0;
        else if (state_q == IDLE && accept)   any_one_q <= 1'b0;
        else if (state_q == EXEC)             any_one_q <= any_one_q | alu_res;
    end

    assign res_zero = (state_q == DONE) && !any_one_q;
`endif

endmodule

// File: tb/tb_alu_bitserial_sched.sv
// Self-checking bench for alu_bitserial_sched with WIDTH=4 and a behavioural ALU.
module tb_alu_bitserial_sched;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a, req_b;
    logic [3:0]     req_op;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_data;
    logic           res_id;
    logic           alu_a, alu_b, alu_res;
    logic [1:0]     alu_ctrl;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic           res_zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    alu_bitserial_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .res_zero  (res_zero),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res)
    );

    // clock / reset
    always #5 clk = ~clk;

    // 1-bit ALU the scheduler is shared in front of
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_res = alu_a & alu_b;
            2'b01:   alu_res = alu_a | alu_b;
            2'b10:   alu_res = alu_a ^ alu_b;
            default: alu_res = ~alu_a;
        endcase
    end

    // word-level reference for a whole operation
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // driver tasks
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_op[i*2 +: 2] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        set_req(0, 4'hF, 4'hF, 2'b01);
        set_req(1, 4'hF, 4'hF, 2'b01);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got=%b exp=0", res_id); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 4'b0) begin errors++; $display("FAIL reset_alu got=%b%b%b exp=0000", alu_a, alu_b, alu_ctrl); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        checks++; if (res_zero !== 1'b0) begin errors++; $display("FAIL reset_res_zero got=%b exp=0", res_zero); end
`endif
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [W-1:0] a = 4'b1100;
        logic [W-1:0] b = 4'b1010;
        @(negedge clk);
        res_ready = 1'b1;
        set_req(0, a, b, 2'b10);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            req_valid = 2'b00;
            set_req(0, ~a, ~b, 2'b00);
            #1;
            checks++; if (alu_a !== a[k]) begin errors++; $display("FAIL single_alu_a bit=%0d got=%b exp=%b", k, alu_a, a[k]); end
            checks++; if (alu_b !== b[k]) begin errors++; $display("FAIL single_alu_b bit=%0d got=%b exp=%b", k, alu_b, b[k]); end
            checks++; if (alu_ctrl !== 2'b10) begin errors++; $display("FAIL single_alu_ctrl bit=%0d got=%b exp=10", k, alu_ctrl); end
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid bit=%0d got=%b exp=0", k, res_valid); end
        end
        @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_latency res_valid got=%b exp=1", res_valid); end
        checks++; if (res_data !== 4'b0110) begin errors++; $display("FAIL single_data got=%b exp=0110", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", res_id); end
        @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%b exp=0", res_valid); end
    endtask

    task automatic test_arbitration();
        logic seen;
        do_reset();
        @(negedge clk);
        res_ready = 1'b1;
        set_req(0, 4'hF, 4'h3, 2'b00);
        set_req(1, 4'h8, 4'h1, 2'b01);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arb_first got=%b exp=01", req_ready); end
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk); #1;
                if (res_valid) begin seen = 1'b1; break; end
            end
            checks++; if (!seen) begin errors++; $display("FAIL arb_wait%0d res_valid got=0 exp=1", r); end
            checks++; if (res_data !== (r == 0 ? 4'h3 : 4'h9)) begin errors++; $display("FAIL arb_data%0d got=%h exp=%h", r, res_data, (r == 0 ? 4'h3 : 4'h9)); end
            checks++; if (res_id !== r[0]) begin errors++; $display("FAIL arb_id%0d got=%b exp=%b", r, res_id, r[0]); end
            @(negedge clk); #1;
            checks++; if (req_ready !== (r == 0 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_next%0d got=%b exp=%b", r, req_ready, (r == 0 ? 2'b10 : 2'b01)); end
        end
        @(negedge clk);
        req_valid = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (res_valid) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || res_data !== 4'h3 || res_id !== 1'b0) begin errors++; $display("FAIL arb_third got=%b/%h/%b exp=1/3/0", seen, res_data, res_id); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic seen = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        set_req(1, 4'h5, 4'h3, 2'b10);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        for (int n = 0; n < 20; n++) begin
            if (res_valid) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_wait res_valid got=0 exp=1"); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== 4'h6 || res_id !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%b exp=1/6/1/00", n, res_valid, res_data, res_id, req_ready);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_before_hs got=%b exp=1", res_valid); end
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs got=%b exp=0", res_valid); end
    endtask

    task automatic test_reset_mid_exec();
        logic seen = 1'b0;
        @(negedge clk);
        res_ready = 1'b1;
        set_req(0, 4'hF, 4'hF, 2'b01);
        req_valid = 2'b01;
        repeat (2) begin
            @(negedge clk);
            req_valid = 2'b00;
        end
        @(negedge clk); #1;
        checks++; if (alu_a !== 1'b1 || alu_ctrl !== 2'b01) begin errors++; $display("FAIL mid_in_exec got=%b/%b exp=1/01", alu_a, alu_ctrl); end
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== 4'b0 || res_valid !== 1'b0 || res_data !== '0 ||
            res_id !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b%b%b/%b/%h/%b/%b exp=0000/0/0/0/00",
                     alu_a, alu_b, alu_ctrl, res_valid, res_data, res_id, req_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk); #1;
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_no_result cyc=%0d got=%b exp=0", n, res_valid); end
        end
        @(negedge clk);
        set_req(0, 4'h9, 4'hC, 2'b10);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_regrant got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (res_valid) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || res_data !== 4'h5 || res_id !== 1'b0) begin errors++; $display("FAIL mid_after got=%b/%h/%b exp=1/5/0", seen, res_data, res_id); end
        @(negedge clk);
    endtask

`ifdef ALU_SEQ_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [W-1:0] za[2]  = '{4'b1010, 4'b0000};
        logic [W-1:0] zb[2]  = '{4'b0101, 4'b0001};
        logic [1:0]   zop[2] = '{2'b00, 2'b01};
        logic seen;
        for (int t = 0; t < 2; t++) begin
            seen = 1'b0;
            @(negedge clk);
            res_ready = 1'b1;
            set_req(0, za[t], zb[t], zop[t]);
            req_valid = 2'b01;
            @(negedge clk);
            req_valid = 2'b00;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk); #1;
                if (res_valid) begin seen = 1'b1; break; end
            end
            checks++; if (!seen || res_data !== ref_op(za[t], zb[t], zop[t])) begin errors++; $display("FAIL zero_data%0d got=%h exp=%h", t, res_data, ref_op(za[t], zb[t], zop[t])); end
            checks++; if (res_zero !== (t == 0)) begin errors++; $display("FAIL zero_flag%0d got=%b exp=%b", t, res_zero, (t == 0)); end
            @(negedge clk);
        end
    endtask
`endif

    // randomized traffic against the arbitration/timing model and exp_q scoreboard
    task automatic test_random();
        logic [W-1:0] pa[2], pb[2], ca, cb;
        logic [1:0]   pop[2], cop;
        logic [1:0]   pv = 2'b00;
        logic [1:0]   exp_rdy;
        logic [W:0]   item;
        logic         g;
        int ptr = 0;
        int phase = 0;
        ca = '0; cb = '0; cop = '0;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0) begin
                    pv[i]  = 1'b1;
                    pa[i]  = W'($urandom);
                    pb[i]  = W'($urandom);
                    pop[i] = 2'($urandom_range(0, 3));
                end else if (pv[i] && phase != 0 && $urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
                set_req(i, pa[i], pb[i], pop[i]);
            end
            req_valid = pv;
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = (phase != 0) ? 2'b00 : (pv == 2'b11) ? (2'b01 << ptr) : pv;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            if (phase >= 1 && phase <= W) begin
                checks++;
                if (alu_a !== ca[phase-1] || alu_b !== cb[phase-1] || alu_ctrl !== cop || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_exec cyc=%0d got=%b%b%b/%b exp=%b%b%b/0", cyc, alu_a, alu_b, alu_ctrl, res_valid, ca[phase-1], cb[phase-1], cop);
                end
            end else begin
                checks++;
                if ({alu_a, alu_b, alu_ctrl} !== 4'b0 || res_valid !== (phase == W + 1)) begin
                    errors++;
                    $display("FAIL rand_idle cyc=%0d got=%b%b%b/%b exp=0000/%b", cyc, alu_a, alu_b, alu_ctrl, res_valid, (phase == W + 1));
                end
                if (phase == W + 1 && res_ready) begin
                    item = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                    checks++; if ({res_id, res_data} !== item) begin errors++; $display("FAIL rand_result cyc=%0d got=%b/%h exp=%b/%h", cyc, res_id, res_data, item[W], item[W-1:0]); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    checks++; if (res_zero !== (item[W-1:0] == '0)) begin errors++; $display("FAIL rand_zero cyc=%0d got=%b exp=%b", cyc, res_zero, (item[W-1:0] == '0)); end
`endif
                end
            end
            if (phase == 0) begin
                if (exp_rdy != 2'b00) begin
                    g     = exp_rdy[1];
                    ca    = pa[g];
                    cb    = pb[g];
                    cop   = pop[g];
                    exp_q.push_back({g, ref_op(pa[g], pb[g], pop[g])});
                    ptr   = g ? 0 : 1;
                    pv[g] = 1'b0;
                    phase = 1;
                end
            end else if (phase <= W) begin
                phase++;
            end else if (res_ready) begin
                phase = 0;
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        test_reset();
        test_single();
        test_arbitration();
        test_back_pressure();
        test_reset_mid_exec();
`ifdef ALU_SEQ_ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
